// File: rtl/led_share_sched_if.sv
// Status-source <-> LED scheduler bundle: per-requester request/mode in,
// current owner, LED drive and busy flag out.
interface led_share_sched_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [2*N-1:0] mode;
  logic [N-1:0]   grant;
  logic           led;
  logic           busy;

  modport master (output req, output mode, input grant, input led, input busy);
  modport slave  (input req, input mode, output grant, output led, output busy);
endinterface

// File: rtl/led_share_sched.sv
// Round-robin time-sharing of one LED between N status sources, with minimum
// hold and forced-off gap. Optional IDLE heartbeat: define LED_SHARE_HEARTBEAT_EN.
module led_share_sched #(
  parameter int N         = 4,
  parameter int PRESC_W   = 20,
  parameter int MIN_HOLD  = 8,
  parameter int GAP_TICKS = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  led_share_sched_if.slave   bus
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] HOLD_INIT = 8'(MIN_HOLD);
  localparam logic [3:0] GAP_INIT  = 4'(GAP_TICKS);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [3:0]           phase_q, phase_d;
  logic [LW-1:0]        last_q, last_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic [N-1:0]         grant_q, grant_d;
  logic                 led_q, led_d;

  logic                 tick;
  logic                 any_req;
  logic                 others_req;
  logic                 owner_req;
  logic                 found;
  logic [LW-1:0]        win_idx;
  logic [N-1:0]         win_oh;
  logic [LW:0]          rr_sum;
  logic [1:0]           owner_mode;
  logic [1:0]           mode_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_mode
    assign mode_arr[gi] = bus.mode[2*gi+1 : 2*gi];
  end

  assign tick       = &presc_q;
  assign any_req    = |bus.req;
  assign others_req = |(bus.req & ~grant_q);
  assign owner_req  = |(bus.req & grant_q);
  // While in HOLD the owner is always the most recent winner.
  assign owner_mode = mode_arr[last_q];

  // Scan (last+1) .. (last+N) mod N; first requester found wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    rr_sum  = '0;
    for (int k = 1; k <= N; k++) begin
      rr_sum = (LW+1)'(last_q) + (LW+1)'(k);
      if (rr_sum >= (LW+1)'(N)) begin
        rr_sum = rr_sum - (LW+1)'(N);
      end
      if (!found && bus.req[rr_sum[LW-1:0]]) begin
        found   = 1'b1;
        win_idx = rr_sum[LW-1:0];
      end
    end
  end

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  always_comb begin
    presc_d    = presc_q + 1'b1;
    phase_d    = phase_q + {3'b000, tick};
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    grant_d    = grant_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = HOLD;
          grant_d    = win_oh;
          last_d     = win_idx;
          hold_cnt_d = HOLD_INIT;
        end
      end
      HOLD: begin
        // Expiry is judged on the pre-tick count; the decrement waits a cycle.
        if (hold_cnt_q == 8'd0) begin
          if (others_req) begin
            state_d   = GAP;
            grant_d   = '0;
            gap_cnt_d = GAP_INIT;
          end else if (owner_req) begin
            hold_cnt_d = HOLD_INIT;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (tick) begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) begin
          if (any_req) begin
            state_d    = HOLD;
            grant_d    = win_oh;
            last_d     = win_idx;
            hold_cnt_d = HOLD_INIT;
          end else begin
            state_d = IDLE;
          end
        end else if (tick) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    led_d = 1'b0;
    case (state_q)
      HOLD: begin
        case (owner_mode)
          2'b00:   led_d = 1'b0;
          2'b01:   led_d = 1'b1;
          2'b10:   led_d = phase_q[3];
          default: led_d = phase_q[1];
        endcase
      end
      IDLE: begin
`ifdef LED_SHARE_HEARTBEAT_EN
        led_d = (phase_q == 4'd0);
`else
        led_d = 1'b0;
`endif
      end
      default: led_d = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_q    <= '0;
      phase_q    <= '0;
      state_q    <= IDLE;
      last_q     <= LW'(N-1);
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      grant_q    <= '0;
      led_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      grant_q    <= grant_d;
      led_q      <= led_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.led   = led_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_led_share_sched.sv
// Directed bench for led_share_sched (N=4, PRESC_W=4 -> tick every 16 cycles,
// MIN_HOLD=3, GAP_TICKS=2); outputs sampled on the falling edge.
module tb_led_share_sched;

  localparam int N = 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_vec     = 0;
  int   n_bad     = 0;

  led_share_sched_if #(.N(N)) bus ();

  led_share_sched #(
    .N(N), .PRESC_W(4), .MIN_HOLD(3), .GAP_TICKS(2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    bus.req   = '0;
    bus.mode  = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // Counts falling edges until grant changes (bounded); led is accumulated over
  // the samples strictly inside the segment, skipping its first sample.
  task automatic wait_grant_change(output logic [3:0] g, output int n,
                                   output logic led_or, output logic led_and);
    logic [3:0] cur;
    cur     = bus.grant;
    n       = 0;
    led_or  = 1'b0;
    led_and = 1'b1;
    while (n < 400) begin
      @(negedge sys_clk);
      n++;
      if (bus.grant !== cur) break;
      led_or  = led_or | bus.led;
      led_and = led_and & bus.led;
    end
    g = bus.grant;
  endtask

  task automatic wait_led_change(output int n);
    logic cur;
    cur = bus.led;
    n   = 0;
    while (n < 200) begin
      @(negedge sys_clk);
      n++;
      if (bus.led !== cur) break;
    end
  endtask

  logic [3:0] exp_seq [8];
  logic [3:0] g;
  int         n;
  logic       lo, la;
  logic       bad_flag;
  int         ticks;

  initial begin
    exp_seq = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    // Test 1: reset state and quiet idle
    bus.req  = '0;
    bus.mode = '0;
    #1;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_led",   32'(bus.led),   32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    do_reset();
    bad_flag = 1'b0;
    ticks    = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (bus.grant !== 4'd0 || bus.led !== 1'b0 || bus.busy !== 1'b0) bad_flag = 1'b1;
      if (i < 96 && dut.tick === 1'b1) ticks++;
    end
    check("idle_quiet",   32'(bad_flag), 32'd0);
    check("ticks_per_96", 32'(ticks),    32'd6);

    // Test 2: single requester, solid on, hold re-arms
    bus.req  = 4'b0001;
    bus.mode = 8'b0000_0001;
    @(negedge sys_clk);
    check("t2_grant", 32'(bus.grant), 32'b0001);
    check("t2_led0",  32'(bus.led),   32'd0);
    check("t2_busy",  32'(bus.busy),  32'd1);
    @(negedge sys_clk);
    check("t2_led1",  32'(bus.led),   32'd1);
    bad_flag = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (bus.grant !== 4'b0001 || bus.led !== 1'b1) bad_flag = 1'b1;
    end
    check("t2_rearm_stable", 32'(bad_flag), 32'd0);
    bus.req = 4'b0000;
    wait_grant_change(g, n, lo, la);
    check("t2_release_grant", 32'(g), 32'd0);
    check("t2_release_bound", 32'(n <= 49), 32'd1);
    check("t2_idle_busy", 32'(bus.busy), 32'd0);
    @(negedge sys_clk);
    check("t2_idle_led", 32'(bus.led), 32'd0);

    // Test 3: all four requesting, round-robin with gaps
    do_reset();
    bus.req  = 4'b1111;
    bus.mode = 8'b0101_0101;
    @(negedge sys_clk);
    check("t3_first_grant", 32'(bus.grant), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      wait_grant_change(g, n, lo, la);
      check($sformatf("t3_seq%0d_grant", i), 32'(g), 32'(exp_seq[i]));
      if (i % 2 == 0) begin
        check($sformatf("t3_seq%0d_hold_len", i), 32'(n), 32'd48);
        check($sformatf("t3_seq%0d_hold_led", i), 32'(la), 32'd1);
      end else begin
        check($sformatf("t3_seq%0d_gap_len", i), 32'(n), 32'd32);
        check($sformatf("t3_seq%0d_gap_led", i), 32'(lo), 32'd0);
      end
      if (i == 0) check("t3_gap_busy", 32'(bus.busy), 32'd1);
    end

    // Test 4: owner 2 slow blink at phase 8..11, drops req after one tick
    do_reset();
    repeat (130) @(posedge sys_clk);
    @(negedge sys_clk);
    bus.req  = 4'b0100;
    bus.mode = 8'b0010_0000;
    @(negedge sys_clk);
    check("t4_grant", 32'(bus.grant), 32'b0100);
    check("t4_led_lag", 32'(bus.led), 32'd0);
    @(negedge sys_clk);
    check("t4_led_phase3", 32'(bus.led), 32'd1);
    repeat (18) @(negedge sys_clk);
    bus.req = 4'b0000;
    repeat (26) @(negedge sys_clk);
    check("t4_min_hold_grant", 32'(bus.grant), 32'b0100);
    check("t4_min_hold_led",   32'(bus.led),   32'd1);
    @(negedge sys_clk);
    check("t4_expire_grant", 32'(bus.grant), 32'd0);
    check("t4_expire_busy",  32'(bus.busy),  32'd0);
    @(negedge sys_clk);
    check("t4_idle_led", 32'(bus.led), 32'd0);

    // Test 5: async reset mid-hold, then last restarts at N-1
    bus.req  = 4'b0100;
    bus.mode = 8'b0001_0000;
    @(negedge sys_clk);
    check("t5_grant", 32'(bus.grant), 32'b0100);
    @(negedge sys_clk);
    check("t5_led", 32'(bus.led), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t5_async_grant", 32'(bus.grant), 32'd0);
    check("t5_async_led",   32'(bus.led),   32'd0);
    check("t5_async_busy",  32'(bus.busy),  32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    bus.req   = 4'b1100;
    @(negedge sys_clk);
    check("t5_rr_after_reset", 32'(bus.grant), 32'b0100);

    // Test 6: fast blink period, then mode 00 mid-hold
    bus.req = 4'b0100;
    @(negedge sys_clk);
    check("t6_led_solid", 32'(bus.led), 32'd1);
    bus.mode = 8'b0011_0000;
    wait_led_change(n);
    check("t6_fast_first", 32'(n), 32'd1);
    wait_led_change(n);
    wait_led_change(n);
    check("t6_fast_period_a", 32'(n), 32'd32);
    wait_led_change(n);
    check("t6_fast_period_b", 32'(n), 32'd32);
    check("t6_grant_kept", 32'(bus.grant), 32'b0100);
    wait_led_change(n);
    bus.mode = 8'b0000_0000;
    @(negedge sys_clk);
    check("t6_mode_off_led",   32'(bus.led),   32'd0);
    check("t6_mode_off_grant", 32'(bus.grant), 32'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
